// File: rtl/cla16_seq_pkg.sv
// Shared definitions for the sequential multi-limb CLA adder.
package cla16_seq_pkg;

    localparam int LIMB_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Limb index width; at least one bit so WORDS=2 still has a real counter.
    function automatic int idx_w(input int words);
        return (words > 2) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/carry_ahead_adder16.sv
// 16-bit carry-lookahead adder slice: 4-bit lookahead groups, group carries
// chained from cin. gm/pm are the block generate/propagate terms.
module carry_ahead_adder16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout,
    output logic        gm,
    output logic        pm
);

    logic [15:0] g;
    logic [15:0] p;

    assign g = a & b;
    assign p = a ^ b;

    // Bit carries come from the group's running generate/propagate, not a ripple chain.
    always_comb begin
        logic grp_g;
        logic grp_p;
        logic bit_c;
        logic grp_c;
        logic blk_g;
        logic blk_p;
        grp_g = 1'b0;
        grp_p = 1'b1;
        bit_c = 1'b0;
        grp_c = cin;
        blk_g = 1'b0;
        blk_p = 1'b1;
        sum   = '0;
        for (int j = 0; j < 4; j++) begin
            grp_g = 1'b0;
            grp_p = 1'b1;
            for (int k = 0; k < 4; k++) begin
                bit_c          = grp_g | (grp_p & grp_c);
                sum[4*j + k]   = p[4*j + k] ^ bit_c;
                grp_g          = g[4*j + k] | (p[4*j + k] & grp_g);
                grp_p          = grp_p & p[4*j + k];
            end
            grp_c = grp_g | (grp_p & grp_c);
            blk_g = grp_g | (grp_p & blk_g);
            blk_p = blk_p & grp_p;
        end
        cout = grp_c;
        gm   = blk_g;
        pm   = blk_p;
    end

endmodule

// File: rtl/cla16_seq_adder.sv
// Multi-cycle wide adder: one 16-bit CLA slice reused across WORDS limbs,
// least-significant limb first, carry held in a register between limbs.
// Optional subtract support is enabled by defining CLA16_SEQ_SUB_EN.
//
//   state | meaning
//   IDLE  | ready for a request; operands captured on accept
//   RUN   | one limb per clock through the slice, idx counts 0..WORDS-1
//   DONE  | result valid and held until the consumer takes it
module cla16_seq_adder
    import cla16_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LIMB_W*WORDS-1:0]   in_a,
    input  logic [LIMB_W*WORDS-1:0]   in_b,
    input  logic                      in_cin,
`ifdef CLA16_SEQ_SUB_EN
    input  logic                      in_sub,
`endif
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LIMB_W*WORDS-1:0]   out_sum,
    output logic                      out_cout,
    output logic                      out_ovf
);

    localparam int W  = LIMB_W * WORDS;
    localparam int IW = idx_w(WORDS);

    state_t           state_q;
    state_t           state_d;
    logic [IW-1:0]    idx_q;
    logic             carry_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     b_load;
    logic             cin_load;
    logic             accept;
    logic             last_limb;
    logic [LIMB_W-1:0] a_limb;
    logic [LIMB_W-1:0] b_limb;
    logic [LIMB_W-1:0] slice_sum;
    logic             slice_cout;
    logic             slice_gm_unused;
    logic             slice_pm_unused;

`ifdef CLA16_SEQ_SUB_EN
    // Subtraction is A + ~B + 1; in_cin has no effect while subtracting.
    assign b_load   = in_sub ? ~in_b : in_b;
    assign cin_load = in_sub | in_cin;
`else
    assign b_load   = in_b;
    assign cin_load = in_cin;
`endif

    assign accept    = in_valid & in_ready;
    assign last_limb = (idx_q == IW'(WORDS - 1));
    assign a_limb    = LIMB_W'(a_q >> (LIMB_W * int'(idx_q)));
    assign b_limb    = LIMB_W'(b_q >> (LIMB_W * int'(idx_q)));

    carry_ahead_adder16 u_slice (
        .a    (a_limb),
        .b    (b_limb),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout),
        .gm   (slice_gm_unused),
        .pm   (slice_pm_unused)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_limb) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, limb sequencing and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            out_sum  <= '0;
            out_cout <= 1'b0;
            out_ovf  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= in_a;
                        b_q     <= b_load;
                        carry_q <= cin_load;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    for (int k = 0; k < WORDS; k++) begin
                        if (idx_q == IW'(k)) begin
                            out_sum[k*LIMB_W +: LIMB_W] <= slice_sum;
                        end
                    end
                    carry_q <= slice_cout;
                    idx_q   <= idx_q + 1'b1;
                    if (last_limb) begin
                        out_cout <= slice_cout;
                        out_ovf  <= a_limb[LIMB_W-1] ^ b_limb[LIMB_W-1]
                                  ^ slice_sum[LIMB_W-1] ^ slice_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cla16_seq_adder.sv
// Bench for cla16_seq_adder: WORDS=4 main instance plus a WORDS=2 instance
// for the short-operand reset case.
module tb_cla16_seq_adder;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        sub;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_a = '0;
    logic [63:0] in_b = '0;
    logic        in_cin = 1'b0;
    logic        in_sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_sum;
    logic        out_cout;
    logic        out_ovf;

    logic        in_valid2 = 1'b0;
    logic        in_ready2;
    logic [31:0] in_a2 = '0;
    logic [31:0] in_b2 = '0;
    logic        in_cin2 = 1'b0;
    logic        in_sub2 = 1'b0;
    logic        out_valid2;
    logic        out_ready2 = 1'b0;
    logic [31:0] out_sum2;
    logic        out_cout2;
    logic        out_ovf2;

    exp_t sb_q[$];
    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    cla16_seq_adder #(.WORDS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef CLA16_SEQ_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    cla16_seq_adder #(.WORDS(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .in_a      (in_a2),
        .in_b      (in_b2),
        .in_cin    (in_cin2),
`ifdef CLA16_SEQ_SUB_EN
        .in_sub    (in_sub2),
`endif
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .out_sum   (out_sum2),
        .out_cout  (out_cout2),
        .out_ovf   (out_ovf2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    endtask

    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic sub);
        logic [63:0] bb;
        logic        cc;
        logic [64:0] s;
        exp_t        e;
        bb     = sub ? ~b : b;
        cc     = sub ? 1'b1 : cin;
        s      = {1'b0, a} + {1'b0, bb} + {64'd0, cc};
        e.sum  = s[63:0];
        e.cout = s[64];
        e.ovf  = (a[63] == bb[63]) && (s[63] != a[63]);
        return e;
    endfunction

    function automatic vec_t mk(input logic [63:0] a, input logic [63:0] b, input logic cin,
                                input logic sub, input logic [63:0] sum, input logic cout,
                                input logic ovf);
        vec_t v;
        v.a = a; v.b = b; v.cin = cin; v.sub = sub;
        v.e.sum = sum; v.e.cout = cout; v.e.ovf = ovf;
        return v;
    endfunction

    // Called just after a clock edge; returns #1 after the accept edge.
    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic cin,
                        input logic sub, input exp_t e);
        int n;
        n = 0;
        in_a = a; in_b = b; in_cin = cin; in_sub = sub;
        in_valid = 1'b1;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk("accept_wait", 64'(n < 40), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb_q.push_back(e);
    endtask

    task automatic receive(input bit check_lat, input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (check_lat) chk({tag, "_latency"}, 64'(n), 64'd4);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_sum"},  out_sum, e.sum);
            chk({tag, "_cout"}, 64'(out_cout), 64'(e.cout));
            chk({tag, "_ovf"},  64'(out_ovf), 64'(e.ovf));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_idle_after"}, 64'({out_valid, in_ready}), 64'd1);
    endtask

    task automatic run2(input logic [31:0] a, input logic [31:0] b, input logic [31:0] sum,
                        input logic cout, input logic ovf, input string tag);
        int n;
        in_a2 = a; in_b2 = b; in_cin2 = 1'b0; in_sub2 = 1'b0;
        chk({tag, "_ready"}, 64'(in_ready2), 64'd1);
        in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        n = 0;
        while (!out_valid2 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd2);
        chk({tag, "_sum"}, 64'(out_sum2), 64'(sum));
        chk({tag, "_cout_ovf"}, 64'({out_cout2, out_ovf2}), 64'({cout, ovf}));
        out_ready2 = 1'b1;
        @(posedge clk); #1;
        out_ready2 = 1'b0;
    endtask

    initial begin
        exp_t        e1;
        exp_t        e2;
        logic [63:0] ra;
        logic [63:0] rb;
        logic        rc;

        vecs.push_back(mk(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0));
        vecs.push_back(mk(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                          64'h8000_0000_0000_0000, 1'b0, 1'b1));
        vecs.push_back(mk(64'h0000_0000_FFFF_FFFF, 64'd0, 1'b1, 1'b0,
                          64'h0000_0001_0000_0000, 1'b0, 1'b0));
        vecs.push_back(mk(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0,
                          64'd0, 1'b1, 1'b1));
        vecs.push_back(mk(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0,
                          64'd0, 1'b1, 1'b0));
        vecs.push_back(mk(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0,
                          64'h0001_0000_0001_0000, 1'b0, 1'b0));
        vecs.push_back(mk(64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0));
`ifdef CLA16_SEQ_SUB_EN
        vecs.push_back(mk(64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0));
        vecs.push_back(mk(64'd7, 64'd5, 1'b1, 1'b1, 64'd2, 1'b1, 1'b0));
        vecs.push_back(mk(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
                          64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1));
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready_valid", 64'({in_ready, out_valid}), 64'd2);
        chk("rst_sum", out_sum, 64'd0);
        chk("rst_cout_ovf", 64'({out_cout, out_ovf}), 64'd0);
        chk("rst2_state", 64'({in_ready2, out_valid2, out_sum2, out_cout2, out_ovf2}),
            64'h1_0000_0000 << 3);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].e);
            receive(1'b1, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 4; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rc = 1'($urandom_range(0, 1));
            send(ra, rb, rc, 1'b0, model(ra, rb, rc, 1'b0));
            receive(1'b0, $sformatf("rnd%0d", i));
        end

        // Backpressure: result must hold while a second request waits.
        e1 = model(64'h0001_0002_0003_0004, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
        send(64'h0001_0002_0003_0004, 64'h1111_2222_3333_4444, 1'b0, 1'b0, e1);
        for (int n = 0; n < 20 && !out_valid; n++) begin
            @(posedge clk); #1;
        end
        in_a = 64'hFFFF_0000_FFFF_0000; in_b = 64'h0001_0000_0001_0000; in_cin = 1'b0;
        in_sub = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp_hold%0d", i), {out_valid, in_ready, out_sum[61:0]},
                {2'b10, e1.sum[61:0]});
            @(posedge clk); #1;
        end
        chk("bp_hold_msb", 64'({out_sum[63:62], out_cout, out_ovf}),
            64'({e1.sum[63:62], e1.cout, e1.ovf}));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        void'(sb_q.pop_front());
        chk("bp_not_taken_yet", 64'({out_valid, in_ready}), 64'd1);
        @(posedge clk); #1;
        chk("bp_taken", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        e2 = model(64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b0, 1'b0);
        sb_q.push_back(e2);
        receive(1'b1, "bp2");

        // Reset in the middle of RUN after two limbs.
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0,
             model(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_partial", 64'({out_valid, out_sum[31:0]}), 64'h0_FFFF_FFFE);
        rst_n = 1'b0;
        #1;
        chk("abort_ready_valid", 64'({in_ready, out_valid}), 64'd2);
        chk("abort_sum", out_sum, 64'd0);
        chk("abort_cout_ovf", 64'({out_cout, out_ovf}), 64'd0);
        sb_q.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        send(64'd1, 64'd2, 1'b0, 1'b0, model(64'd1, 64'd2, 1'b0, 1'b0));
        receive(1'b1, "after_abort");

        // WORDS=2 instance: normal op, abort after one limb, then clean op.
        run2(32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1, "w2_ovf");
        in_a2 = 32'hFFFF_FFFF; in_b2 = 32'hFFFF_FFFF; in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        @(posedge clk); #1;
        chk("w2_partial", 64'({out_valid2, out_sum2[15:0]}), 64'h0_FFFE);
        rst_n = 1'b0;
        #1;
        chk("w2_abort", 64'({in_ready2, out_valid2, out_sum2, out_cout2, out_ovf2}),
            64'h1_0000_0000 << 3);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run2(32'd1, 32'd2, 32'd3, 1'b0, 1'b0, "w2_after_abort");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cla16_seq_adder.md
# cla16_seq_adder

Multi-cycle wide adder controller that time-multiplexes one 16-bit carry-lookahead adder slice (`carry_ahead_adder16`) across `WORDS` 16-bit limbs. It rippling the carry through a register, one limb per clock. It sits between a valid/ready producer and consumer in the arithmetic datapath, where a full-width combinational adder would cost too much area. The block captures operands, sequences the slice least-significant limb first, and presents the full sum with carry-out and signed overflow.

## Interface
- `WORDS`, default 4: number of 16-bit limbs; legal range 2..8; operand width W = 16*WORDS.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  block can accept a request.
- `in_a`  in  W  operand A.
- `in_b`  in  W  operand B.
- `in_cin`  in  1  carry-in to limb 0.
- `in_sub`  in  1  subtract request; present only with `CLA16_SEQ_SUB_EN`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_sum`  out  W  result.
- `out_cout`  out  1  carry out of limb WORDS-1.
- `out_ovf`  out  1  two's-complement overflow of the W-bit operation.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Output reset values: `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_cout`=0, `out_ovf`=0. Internal limb index, carry register, and operand registers all reset to 0.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&`in_ready`, register `in_a`, `in_b` (inverted if sub), and the carry (`in_cin`, or 1 if sub). Set index=0 and go to RUN.
- RUN:
  - `in_ready`=0.
  - Each cycle the slice adds A[16*idx+:16] + B[16*idx+:16] + carry.
  - At the clock edge, the slice sum is written to `out_sum` limb idx, carry takes the slice `cout`, and idx increments.
  - When idx==WORDS-1, go to DONE.
- DONE:
  - `out_valid`=1; `out_sum`, `out_cout`, and `out_ovf` are held stable until `out_valid`&`out_ready`. The next state is then IDLE.
  - `in_valid` is ignored while not in IDLE.
- `out_ovf` = (A_msb ^ B'_msb ^ sum_msb) ^ `out_cout`, where B' is the B operand after any inversion. It is registered with the final limb.
- The slice `Gm` and `Pm` outputs are unused.
- Reset asserted in any state returns the block immediately to IDLE with the reset values above. The partial result is discarded.

## Timing
- Accept edge T (IDLE→RUN). Limb k is written at edge T+k+1. `out_valid` is high from edge T+WORDS.
- Latency from accept to `out_valid` is WORDS cycles.
- Handshake at edge U (DONE→IDLE). `in_ready` is high after edge U; the earliest next accept is edge U+1.
- No overlap between operations. The maximum rate is one operation per WORDS+2 cycles with `out_ready` tied high.
- The critical path is one 16-bit CLA slice plus the operand and limb multiplexers, from register to register.

## Configuration
- `CLA16_SEQ_SUB_EN` defined:
  - The `in_sub` port exists.
  - When sub=1, B is stored inverted and carry is initialised to 1, so the result is A−B; `in_cin` is ignored.
  - `out_cout`=1 means no borrow.
- `CLA16_SEQ_SUB_EN` undefined:
  - The `in_sub` port is absent, and there is no inverter or mux logic.
  - The block performs addition only, using `in_cin`.

## Structure
- Shared package `cla16_seq_pkg` contains:
  - FSM state enum (IDLE/RUN/DONE).
  - `LIMB_W`=16.
  - Index width function clog2(WORDS).
- One sub-module: a single instance of `carry_ahead_adder16` as the shared slice. All sequencing stays in `cla16_seq_adder`.

## Test plan
All scenarios use WORDS=4 unless noted.
- **Full carry ripple:** A=0xFFFF_FFFF_FFFF_FFFF, B=1, cin=0 → sum=0, cout=1, ovf=0. `out_valid` rises exactly 4 cycles after accept.
- **Signed overflow:** A=0x7FFF_FFFF_FFFF_FFFF, B=1 → sum=0x8000_0000_0000_0000, cout=0, ovf=1.
- **Carry across limbs:** A=0x0000_0000_FFFF_FFFF, B=0, cin=1 → sum=0x0000_0001_0000_0000, cout=0.
- **Subtract (`CLA16_SEQ_SUB_EN`):** A=5, B=7, sub=1 → sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0. A=7, B=5 → sum=2, cout=1.
- **Backpressure:** hold `out_ready`=0 for 10 cycles while driving a new `in_valid` → `out_valid` and `out_sum` stay stable, `in_ready`=0, and the second request is not taken until 1 cycle after the handshake.
- **Reset mid-RUN:** drop `rst_n` after 2 limbs → outputs go to reset values immediately and `in_ready`=1. After release, A=1, B=2 gives sum=3 with no residue from the aborted operation. Repeat with WORDS=2.
